// File: rtl/piso_serializer.sv
// Parallel-in / serial-out frame serializer with valid/ready load handshake,
// shift stall, and gapless back-to-back frames.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State, shift register and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, handshake and frame-end decode
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt_q == '0) begin
            // Last bit consumed; a word offered now starts the next frame with no gap
            done       = 1'b1;
            load_ready = 1'b1;
            if (load_valid) begin
              shreg_d = load_data;
              cnt_d   = CNT_W'(WIDTH - 1);
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            if (MSB_FIRST != 0) begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign serial_valid = (state_q == SHIFT);
  assign busy         = (state_q == SHIFT);
  assign serial_out   = (state_q == SHIFT) &&
                        ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances share
// stimulus; each scenario task checks the observed outputs cycle by cycle.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [3:0] load_data;
  logic       shift_en;

  logic lr_m, so_m, sv_m, busy_m, done_m;
  logic lr_l, so_l, sv_l, busy_l, done_l;

  // {serial_out, serial_valid, busy, done, load_ready}
  logic [4:0] obs_m, obs_l;
  assign obs_m = {so_m, sv_m, busy_m, done_m, lr_m};
  assign obs_l = {so_l, sv_l, busy_l, done_l, lr_l};

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_m), .shift_en(shift_en), .serial_out(so_m),
    .serial_valid(sv_m), .busy(busy_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(lr_l), .shift_en(shift_en), .serial_out(so_l),
    .serial_valid(sv_l), .busy(busy_l), .done(done_l)
  );

  // Drive inputs at the falling edge for the next rising edge, then settle
  task automatic drive(input logic lv, input logic [3:0] ld, input logic se);
    @(negedge clk);
    load_valid = lv;
    load_data  = ld;
    shift_en   = se;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load_valid = 1'b1; load_data = 4'b1010; shift_en = 1'b1;
    #3;
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL reset_async_m: got %b want 00001", obs_m);
    else pass_cnt++;
    total_cnt++;
    if (obs_l !== 5'b00001) $display("FAIL reset_async_l: got %b want 00001", obs_l);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL reset_held_clocked: got %b want 00001", obs_m);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0; load_data = 4'b0000;
    #1;
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL idle_after_reset: got %b want 00001", obs_m);
    else pass_cnt++;
  endtask

  task automatic test_msb_first;
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    drive(1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, 1'b1);
      total_cnt++;
      if (obs_m !== {exp_bits[3-i], 1'b1, 1'b1, (i == 3), (i == 3)})
        $display("FAIL msb_bit%0d: got %b want %b", i, obs_m,
                 {exp_bits[3-i], 1'b1, 1'b1, (i == 3), (i == 3)});
      else pass_cnt++;
    end
    drive(1'b0, 4'b0000, 1'b1);
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL msb_idle_after: got %b want 00001", obs_m);
    else pass_cnt++;
  endtask

  task automatic test_lsb_first;
    logic [3:0] exp_bits;
    exp_bits = 4'b1101;  // LSB-first order of 1011, listed first-bit-in-MSB
    drive(1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, 1'b1);
      total_cnt++;
      if (obs_l !== {exp_bits[3-i], 1'b1, 1'b1, (i == 3), (i == 3)})
        $display("FAIL lsb_bit%0d: got %b want %b", i, obs_l,
                 {exp_bits[3-i], 1'b1, 1'b1, (i == 3), (i == 3)});
      else pass_cnt++;
    end
    drive(1'b0, 4'b0000, 1'b1);
    total_cnt++;
    if (obs_l !== 5'b00001) $display("FAIL lsb_idle_after: got %b want 00001", obs_l);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0110;
    drive(1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive((i < 4), 4'b0110, 1'b1);
      total_cnt++;
      if (obs_m !== {exp_bits[7-i], 1'b1, 1'b1, (i == 3 || i == 7), (i == 3 || i == 7)})
        $display("FAIL b2b_bit%0d: got %b want %b", i, obs_m,
                 {exp_bits[7-i], 1'b1, 1'b1, (i == 3 || i == 7), (i == 3 || i == 7)});
      else pass_cnt++;
    end
    drive(1'b0, 4'b0000, 1'b1);
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL b2b_idle_after: got %b want 00001", obs_m);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    logic [5:0] se_seq, exp_so;
    se_seq = 6'b100111;
    exp_so = 6'b100011;
    drive(1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b0000, se_seq[5-i]);
      total_cnt++;
      if (obs_m !== {exp_so[5-i], 1'b1, 1'b1, (i == 5), (i == 5)})
        $display("FAIL stall_cycle%0d: got %b want %b", i, obs_m,
                 {exp_so[5-i], 1'b1, 1'b1, (i == 5), (i == 5)});
      else pass_cnt++;
    end
    drive(1'b0, 4'b0000, 1'b1);
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL stall_idle_after: got %b want 00001", obs_m);
    else pass_cnt++;
  endtask

  task automatic test_ignore_load;
    drive(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 1) ? 4'bxxxx : 4'b1111, 1'b1);
      total_cnt++;
      if (obs_m !== {1'b0, 1'b1, 1'b1, (i == 3), (i == 3)})
        $display("FAIL ignore_bit%0d: got %b want %b", i, obs_m,
                 {1'b0, 1'b1, 1'b1, (i == 3), (i == 3)});
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, 1'b1);
      total_cnt++;
      if (obs_m !== {1'b1, 1'b1, 1'b1, (i == 3), (i == 3)})
        $display("FAIL ignore_next_bit%0d: got %b want %b", i, obs_m,
                 {1'b1, 1'b1, 1'b1, (i == 3), (i == 3)});
      else pass_cnt++;
    end
    drive(1'b0, 4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid;
    logic [3:0] exp_bits;
    exp_bits = 4'b0101;
    drive(1'b1, 4'b1011, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    total_cnt++;
    if (obs_m !== 5'b01100) $display("FAIL pre_abort_bit1: got %b want 01100", obs_m);
    else pass_cnt++;
    drive(1'b0, 4'b0000, 1'b1);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL abort_immediate: got %b want 00001", obs_m);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL abort_held: got %b want 00001", obs_m);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b1; load_data = 4'b0101; shift_en = 1'b1;
    #1;
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL post_abort_ready: got %b want 00001", obs_m);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, 1'b1);
      total_cnt++;
      if (obs_m !== {exp_bits[3-i], 1'b1, 1'b1, (i == 3), (i == 3)})
        $display("FAIL post_abort_bit%0d: got %b want %b", i, obs_m,
                 {exp_bits[3-i], 1'b1, 1'b1, (i == 3), (i == 3)});
      else pass_cnt++;
    end
    drive(1'b0, 4'b0000, 1'b1);
    total_cnt++;
    if (obs_m !== 5'b00001) $display("FAIL post_abort_idle: got %b want 00001", obs_m);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_ignore_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
